rr_output_arbiter: RTL and testbench

Parametrised per-output-port switch arbiter for the mesh router. It takes one request line per input port and produces a one-hot grant. Round-robin fairness replaces fixed priority, and the grant is held for a whole wormhole packet. One instance sits at each router output and drives that output's crossbar select. No input combination produces an undefined select: the output is all-zero when idle.

---
 rtl/rr_output_arbiter.sv | 87 ++++++++
 tb/tb_rr_output_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_output_arbiter.sv
// Per-output round-robin switch arbiter: one-hot crossbar select, held for a whole wormhole packet.
// State | meaning:  IDLE = free, grant follows req from ptr  |  LOCKED = mid-packet, grant pinned to owner
module rr_output_arbiter #(
  parameter int N_PORTS = 5,
  parameter bit RR_EN   = 1'b1,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               fire,
  output logic [N_PORTS-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             accept;
  logic             tail_g;
  logic [IDX_W-1:0] next_ptr;

  // Cyclic search from ptr; the extra sum bit keeps the wrap exact for non-power-of-two N_PORTS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_PORTS)) sum = sum - (IDX_W+1)'(N_PORTS);
      cand = sum[IDX_W-1:0];
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (state == LOCKED) begin
      grant[owner] = 1'b1;
      grant_idx    = owner;
    end else if (sel_found) begin
      grant[sel_idx] = 1'b1;
      grant_idx      = sel_idx;
    end
  end

  assign grant_valid = |(grant & req);
  assign locked      = (state == LOCKED);
  assign accept      = fire & grant_valid;
  assign tail_g      = tail[grant_idx];
  assign next_ptr    = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // fire without a valid grant is a protocol error and leaves all state untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        if (!tail_g) begin
          state <= LOCKED;
          owner <= grant_idx;
        end
      end else if (tail_g) begin
        state <= IDLE;
      end
      if (RR_EN && tail_g) ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for reset/mode corners, random run vs. a packet-level model.
module tb_rr_output_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: 5 ports, round-robin
  logic [4:0] req0 = '0, tail0 = '0, grant0;
  logic       fire0 = 1'b0, gv0, lk0;
  logic [2:0] idx0;
  // fixed priority instance
  logic [4:0] reqf = '0, tailf = '0, grantf;
  logic       firef = 1'b0, gvf, lkf;
  logic [2:0] idxf;
  // 3-port instance
  logic [2:0] req3 = '0, tail3 = '0, grant3;
  logic       fire3 = 1'b0, gv3, lk3;
  logic [1:0] idx3;

  rr_output_arbiter #(.N_PORTS(5), .RR_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .tail(tail0), .fire(fire0),
    .grant(grant0), .grant_valid(gv0), .grant_idx(idx0), .locked(lk0));

  rr_output_arbiter #(.N_PORTS(5), .RR_EN(1'b0)) dutf (
    .clk(clk), .rst(rst), .req(reqf), .tail(tailf), .fire(firef),
    .grant(grantf), .grant_valid(gvf), .grant_idx(idxf), .locked(lkf));

  rr_output_arbiter #(.N_PORTS(3), .RR_EN(1'b1)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .tail(tail3), .fire(fire3),
    .grant(grant3), .grant_valid(gv3), .grant_idx(idx3), .locked(lk3));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       fire;
    logic [4:0] grant;
    logic [2:0] idx;
    logic       gv;
    logic       locked;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // packet-level reference model state for dut0
  int m_lock, m_owner, m_ptr, eg_idx;
  logic [4:0] eg;
  logic egv;

  initial begin
    // fairness: everyone requests single-flit packets
    tbl[0]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{5'b11111, 5'b11111, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{5'b11111, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
    tbl[3]  = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
    tbl[4]  = '{5'b11111, 5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
    tbl[5]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
    // wormhole: port 2 sends 4 flits while 0 and 4 request (ptr=1)
    tbl[6]  = '{5'b10101, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
    tbl[7]  = '{5'b10101, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    tbl[8]  = '{5'b10101, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    tbl[9]  = '{5'b10101, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1};
    tbl[10] = '{5'b10001, 5'b10001, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
    tbl[11] = '{5'b10001, 5'b10001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
    // bubble: port 1 locked, drops req for 2 cycles while port 3 requests
    tbl[12] = '{5'b01010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
    tbl[13] = '{5'b01000, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b0, 1'b1};
    tbl[14] = '{5'b01000, 5'b01000, 1'b1, 5'b00010, 3'd1, 1'b0, 1'b1};
    tbl[15] = '{5'b01010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1};
    tbl[16] = '{5'b01010, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1};
    tbl[17] = '{5'b01010, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b0};
    tbl[18] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0};
    // set up port 3 lock with ptr=4
    tbl[19] = '{5'b01000, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
    tbl[20] = '{5'b01000, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
    tbl[21] = '{5'b01001, 5'b00000, 1'b0, 5'b01000, 3'd3, 1'b1, 1'b1};

    // reset with requests present: outputs follow req combinationally
    rst  = 1'b1;
    req0 = 5'b10110;
    #2;
    chk("rst_grant", 32'(grant0), 32'(5'b00010));
    chk("rst_idx", 32'(idx0), 32'd1);
    chk("rst_locked", 32'(lk0), 32'd0);
    req0 = '0;
    #1;
    chk("rst_idle_grant", 32'(grant0), 32'd0);
    chk("rst_idle_gv", 32'(gv0), 32'd0);
    chk("rst_idle_idx", 32'(idx0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req0 = tbl[i].req; tail0 = tbl[i].tail; fire0 = tbl[i].fire;
      #2;
      chk($sformatf("vec%0d_grant", i), 32'(grant0), 32'(tbl[i].grant));
      chk($sformatf("vec%0d_idx", i), 32'(idx0), 32'(tbl[i].idx));
      chk($sformatf("vec%0d_gv", i), 32'(gv0), 32'(tbl[i].gv));
      chk($sformatf("vec%0d_locked", i), 32'(lk0), 32'(tbl[i].locked));
      @(posedge clk); #1;
    end

    // reset mid-packet (locked to 3, ptr=4), asserted between edges
    req0 = 5'b01001; tail0 = '0; fire0 = 1'b0;
    #2;
    chk("pre_rst_locked", 32'(lk0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_locked", 32'(lk0), 32'd0);
    chk("midrst_grant", 32'(grant0), 32'(5'b00001));
    @(posedge clk); #1;
    rst = 1'b0;
    tail0 = 5'b00001; fire0 = 1'b1;
    #1;
    chk("postrst_grant", 32'(grant0), 32'(5'b00001));
    @(posedge clk); #1;
    fire0 = 1'b0; tail0 = '0;
    #1;
    chk("postrst_next_grant", 32'(grant0), 32'(5'b01000));

    // fixed priority: lowest index always wins, pointer frozen
    reqf = 5'b11000; tailf = 5'b11000; firef = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("fixed%0d_grant", i), 32'(grantf), 32'(5'b01000));
      @(posedge clk); #1;
    end
    reqf = 5'b10001; tailf = 5'b10001;
    #2;
    chk("fixed_low_grant", 32'(grantf), 32'(5'b00001));
    firef = 1'b0; reqf = '0;

    // 3-port fairness: wrap 2 -> 0
    req3 = 3'b111; tail3 = 3'b111; fire3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #2;
      chk($sformatf("n3_%0d_idx", i), 32'(idx3), 32'(i % 3));
      chk($sformatf("n3_%0d_grant", i), 32'(grant3), 32'(1 << (i % 3)));
      @(posedge clk); #1;
    end
    fire3 = 1'b0; req3 = '0;

    // random run against the packet-level model
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_lock = 0; m_owner = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req0  = ($urandom_range(0, 19) == 0) ? 5'b0 : (5'($urandom) | 5'($urandom));
      tail0 = 5'($urandom) & 5'($urandom);
      fire0 = ($urandom_range(0, 3) != 0);
      eg = '0; eg_idx = 0;
      if (m_lock != 0) begin
        eg_idx = m_owner;
        eg[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (req0[(m_ptr + k) % 5]) begin
            eg_idx = (m_ptr + k) % 5;
            eg[eg_idx] = 1'b1;
            break;
          end
        end
      end
      egv = |(eg & req0);
      #2;
      chk($sformatf("rnd%0d_grant", cyc), 32'(grant0), 32'(eg));
      chk($sformatf("rnd%0d_idx", cyc), 32'(idx0), 32'(eg_idx));
      chk($sformatf("rnd%0d_gv", cyc), 32'(gv0), 32'(egv));
      chk($sformatf("rnd%0d_locked", cyc), 32'(lk0), 32'(m_lock));
      if (fire0 && egv) begin
        if (tail0[eg_idx]) begin
          m_lock = 0;
          m_ptr  = (eg_idx + 1) % 5;
        end else if (m_lock == 0) begin
          m_lock  = 1;
          m_owner = eg_idx;
        end
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
